tart_bank_scheduler: RTL and testbench
======================================

TART_BANK_SCHEDULER -- requirements
Module: tart_bank_scheduler

Interface
REQ-001 Parameter ACCUM, default 24: width of the block-size and sample counter.
REQ-002 Parameter XBITS, default 4: width of the block counter.
REQ-003 Parameter DRAIN, default 3: number of cycles switch_o is held high per bank swap; legal range 1..15.
REQ-004 Ports:
  clk_i        in   1      single system clock; all logic on its rising edge
  rst_i        in   1      synchronous, active-high reset
  enable_i     in   1      correlation enable
  strobe_i     in   1      one-cycle pulse per antenna sample
  blocksize_i  in   ACCUM  block length minus one, in samples
  streamed_i   in   1      one-cycle pulse: read-back of the available bank is complete
  clear_i      in   1      clears overflow_o
  switch_o     out  1      bank-swap in progress (drives correlator switch)
  bank_o       out  1      bank currently being accumulated
  block_o      out  XBITS  count of completed blocks (modulo 2^XBITS)
  available_o  out  1      a completed bank awaits read-back
  overflow_o   out  1      sticky: a completed bank was overwritten before read-back
  busy_o       out  1      scheduler not in IDLE
  count_o      out  ACCUM  samples counted in the current block

Function
REQ-005 The block SHALL implement three states: IDLE, COUNT, SWITCH; busy_o SHALL be 1 in COUNT and SWITCH.
REQ-006 IDLE -> COUNT SHALL occur on the cycle after enable_i=1 is sampled; on that transition blocksize_i SHALL be latched into bs_r and count_o SHALL be 0.
REQ-007 bs_r SHALL be max(blocksize_i, DRAIN), so a block is never shorter than DRAIN+1 strobes.
REQ-008 In COUNT and SWITCH, each strobe_i SHALL increment count_o by 1; a strobe with count_o == bs_r is the terminal strobe and SHALL set count_o to 0 instead.
REQ-009 The terminal strobe in COUNT SHALL cause a transition to SWITCH on the next cycle; on that same edge switch_o SHALL rise and bank_o SHALL toggle.
REQ-010 switch_o SHALL stay high for exactly DRAIN cycles; then the state SHALL return to COUNT (enable_i=1) or IDLE (enable_i=0), and switch_o SHALL fall.
REQ-011 On the edge where switch_o falls, block_o SHALL increment by 1 (wrapping at 2^XBITS) and available_o SHALL be set.
REQ-012 If available_o is already 1 on that edge, overflow_o SHALL be set; it SHALL remain set until clear_i or rst_i.
REQ-013 streamed_i SHALL clear available_o on the next edge; if streamed_i coincides with the set in REQ-011, available_o SHALL be 1 (set wins), and overflow_o SHALL NOT be set.
REQ-014 clear_i coinciding with an overflow event SHALL leave overflow_o at 1.
REQ-015 enable_i=0 in COUNT SHALL move the state to IDLE on the next edge, with count_o cleared, the partial block discarded, and no toggle of bank_o or block_o.
REQ-016 enable_i=0 in SWITCH SHALL NOT abort the swap; the swap SHALL complete per REQ-010/011 and the state then goes to IDLE.
REQ-017 Strobes in IDLE SHALL be ignored.
REQ-018 blocksize_i changes SHALL take effect only at the next IDLE -> COUNT transition.

Reset
REQ-019 With rst_i=1 at a rising edge, the next state SHALL be IDLE with all outputs 0: switch_o, bank_o, block_o, available_o, overflow_o, busy_o, count_o.
REQ-020 Reset SHALL take priority over all inputs, including mid-SWITCH; a reset during a swap SHALL NOT produce the block_o increment.

Verification
REQ-021 blocksize_i=7, DRAIN=3, strobe every 12 cycles: switch_o rises 1 cycle after the 8th strobe and lasts 3 cycles; bank_o goes 0->1; block_o=1 and available_o=1 when switch_o falls.
REQ-022 Same setup, no streamed_i, run 2 blocks: second swap sets overflow_o=1, block_o=2, bank_o=0; clear_i pulse -> overflow_o=0 while available_o stays 1.
REQ-023 blocksize_i=0, DRAIN=3, strobe every cycle: swaps every 4 strobes; count_o sequence 0,1,2,3,0; no strobe is lost.
REQ-024 enable_i dropped after 5 of 8 strobes -> IDLE next cycle, count_o=0, bank_o and block_o unchanged; enable_i dropped during SWITCH -> swap completes, block_o increments, then IDLE.
REQ-025 streamed_i on the same cycle as the available_o set edge: available_o=1 and overflow_o=0; a single streamed_i pulse afterwards -> available_o=0.
REQ-026 rst_i asserted during the second cycle of SWITCH: all outputs 0 next cycle; block_o remains 0.

Source files
------------

// File: rtl/tart_bank_scheduler.sv
// tart_bank_scheduler: sample/block counter that swaps correlator banks and tracks read-back of completed banks.
module tart_bank_scheduler #(
    parameter int ACCUM = 24,
    parameter int XBITS = 4,
    parameter int DRAIN = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             strobe_i,
    input  logic [ACCUM-1:0] blocksize_i,
    input  logic             streamed_i,
    input  logic             clear_i,
    output logic             switch_o,
    output logic             bank_o,
    output logic [XBITS-1:0] block_o,
    output logic             available_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic [ACCUM-1:0] count_o
);
    typedef enum logic [1:0] {IDLE, COUNT, SWITCH} state_t;
    state_t state, state_n;
    logic [ACCUM-1:0] bs_r, bs_n, count_n;
    logic [3:0] dc, dc_n;
    logic bank_n, done, term;
    assign switch_o = state == SWITCH;
    assign busy_o = state != IDLE;
    assign term = strobe_i && count_o == bs_r;
    always_comb begin
        state_n = state;
        bs_n = bs_r;
        count_n = count_o;
        dc_n = dc;
        bank_n = bank_o;
        done = 1'b0;
        case (state)
            IDLE: if (enable_i) begin
                state_n = COUNT;
                bs_n = blocksize_i < ACCUM'(DRAIN) ? ACCUM'(DRAIN) : blocksize_i;
                count_n = '0;
            end
            COUNT: if (!enable_i) begin
                state_n = IDLE;
                count_n = '0;
            end else if (strobe_i) begin
                count_n = term ? '0 : count_o + 1'b1;
                if (term) begin
                    state_n = SWITCH;
                    bank_n = ~bank_o;
                    dc_n = '0;
                end
            end
            SWITCH: begin
                count_n = strobe_i ? (term ? '0 : count_o + 1'b1) : count_o;
                dc_n = dc + 1'b1;
                // swap always completes; enable only picks where it lands
                if (dc == 4'(DRAIN - 1)) begin
                    done = 1'b1;
                    state_n = enable_i ? COUNT : IDLE;
                    count_n = enable_i ? count_n : '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            bs_r <= '0;
            count_o <= '0;
            dc <= '0;
            bank_o <= 1'b0;
            block_o <= '0;
            available_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_n;
            bs_r <= bs_n;
            count_o <= count_n;
            dc <= dc_n;
            bank_o <= bank_n;
            block_o <= done ? block_o + 1'b1 : block_o;
            available_o <= done | (available_o & ~streamed_i);
            overflow_o <= (done & available_o & ~streamed_i) | (overflow_o & ~clear_i);
        end
    end
endmodule

// File: tb/tb_tart_bank_scheduler.sv
// tb_tart_bank_scheduler: randomized profiles checked cycle by cycle against a behavioural model.
module tb_tart_bank_scheduler;
    logic clk_i = 1'b0, rst_i, enable_i, strobe_i, streamed_i, clear_i;
    logic [23:0] blocksize_i, count_o;
    logic switch_o, bank_o, available_o, overflow_o, busy_o;
    logic [3:0] block_o;
    int tests = 0, failed = 0;
    int m_st, m_left, m_bs, m_cnt, m_bank, m_blk, m_avl, m_ovf;
    always #5 clk_i = ~clk_i;
    tart_bank_scheduler dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .strobe_i(strobe_i),
        .blocksize_i(blocksize_i), .streamed_i(streamed_i), .clear_i(clear_i),
        .switch_o(switch_o), .bank_o(bank_o), .block_o(block_o), .available_o(available_o),
        .overflow_o(overflow_o), .busy_o(busy_o), .count_o(count_o)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask
    // model: state 0 idle, 1 counting, 2 swapping with m_left cycles of drain remaining
    task automatic model_step();
        bit done;
        if (rst_i) begin
            {m_st, m_left, m_bs, m_cnt, m_bank, m_blk, m_avl, m_ovf} = '0;
            return;
        end
        done = 0;
        if (m_st == 0) begin
            if (enable_i) begin
                m_st = 1;
                m_bs = blocksize_i < 3 ? 3 : int'(blocksize_i);
                m_cnt = 0;
            end
        end else if (m_st == 1) begin
            if (!enable_i) begin
                m_st = 0;
                m_cnt = 0;
            end else if (strobe_i && m_cnt == m_bs) begin
                m_cnt = 0;
                m_st = 2;
                m_left = 3;
                m_bank = 1 - m_bank;
            end else if (strobe_i) m_cnt++;
        end else begin
            if (strobe_i) m_cnt = m_cnt == m_bs ? 0 : m_cnt + 1;
            m_left--;
            if (m_left == 0) begin
                done = 1;
                m_blk = (m_blk + 1) % 16;
                m_st = enable_i ? 1 : 0;
                if (!enable_i) m_cnt = 0;
            end
        end
        m_ovf = (done && m_avl && !streamed_i) ? 1 : (m_ovf && !clear_i);
        m_avl = done ? 1 : (m_avl && !streamed_i);
    endtask
    task automatic compare();
        check("switch", switch_o, m_st == 2);
        check("busy", busy_o, m_st != 0);
        check("bank", bank_o, m_bank);
        check("block", block_o, m_blk);
        check("available", available_o, m_avl);
        check("overflow", overflow_o, m_ovf);
        check("count", count_o, m_cnt);
    endtask
    task automatic run(input int prof, input int n);
        for (int c = 0; c < n; c++) begin
            rst_i = 0;
            if (prof == 0) begin
                enable_i = 1;
                blocksize_i = 7;
                strobe_i = c % 12 == 0;
                streamed_i = $urandom_range(0, 59) == 0;
                clear_i = $urandom_range(0, 39) == 0;
            end else if (prof == 1) begin
                enable_i = 1;
                blocksize_i = 0;
                strobe_i = 1;
                streamed_i = $urandom_range(0, 3) == 0;
                clear_i = $urandom_range(0, 9) == 0;
            end else begin
                rst_i = $urandom_range(0, 149) == 0;
                enable_i = $urandom_range(0, 24) != 0;
                blocksize_i = 24'($urandom_range(0, 9));
                strobe_i = $urandom_range(0, 2) != 0;
                streamed_i = $urandom_range(0, 7) == 0;
                clear_i = $urandom_range(0, 9) == 0;
            end
            model_step();
            @(negedge clk_i);
            compare();
        end
    endtask
    initial begin
        {enable_i, strobe_i, streamed_i, clear_i} = '0;
        blocksize_i = '0;
        rst_i = 1;
        model_step();
        @(negedge clk_i);
        check("reset_busy", busy_o, 0);
        check("reset_count", count_o, 0);
        check("reset_block", block_o, 0);
        compare();
        for (int p = 0; p < 3; p++) begin
            rst_i = 1;
            model_step();
            @(negedge clk_i);
            compare();
            run(p, p == 2 ? 6000 : 1500);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
